bsg_socket_sdo_tx: RTL and testbench

- Parametrised source-synchronous output-channel transmitter for the ASIC/FPGA socket.
- Generalises the fixed four-channel (A-D) output channels with tokens to num_channels_p channels of width_p bits.
- Adds per-channel token-credit flow control, a calibration phase, and credit-overflow detection.
- Sits between core-side valid/ready producers and the sdo pad-side data/valid/token pins.

---
 rtl/bsg_socket_sdo_tx.sv | 94 +++++++++
 tb/tb_bsg_socket_sdo_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bsg_socket_sdo_tx.sv
// bsg_socket_sdo_tx: socket output-channel transmitter with token credits, calibration and overflow flags.
// Define BSG_SOCKET_SDO_TX_TOKEN_DDR_EN to count both token edges as credit returns.
module bsg_socket_sdo_tx #(
  parameter int num_channels_p      = 4,
  parameter int width_p             = 8,
  parameter int credits_p           = 16,
  parameter int credit_decimation_p = 4,
  parameter int calib_cycles_p      = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              en_i,
  input  logic [num_channels_p-1:0]         v_i,
  input  logic [num_channels_p*width_p-1:0] data_i,
  output logic [num_channels_p-1:0]         ready_o,
  output logic [num_channels_p-1:0]         sdo_v_o,
  output logic [num_channels_p*width_p-1:0] sdo_data_o,
  input  logic [num_channels_p-1:0]         sdo_token_i,
  output logic [1:0]                        state_o,
  output logic [num_channels_p-1:0]         credit_err_o
);
  localparam int N   = num_channels_p;
  localparam int W   = width_p;
  localparam int CW  = $clog2(credits_p+1);
  localparam int CNW = $clog2(calib_cycles_p);
  typedef enum logic [1:0] {IDLE = 2'd0, CALIB = 2'd1, RUN = 2'd2} state_e;
  state_e state_q, state_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [N-1:0] s1_q, s2_q, s3_q, v_q, err_q, err_d, ev, send;
  logic [N*W-1:0] data_q, data_d;
  logic [N-1:0][CW-1:0] cred_q, cred_d;
  logic [N-1:0][CW:0] sum;
  logic run, reload;
  assign run = (state_q == RUN) && en_i;
  assign reload = (state_q == IDLE) && (state_d == CALIB);
`ifdef BSG_SOCKET_SDO_TX_TOKEN_DDR_EN
  assign ev = (s2_q ^ s3_q) & {N{state_q == RUN}};
`else
  assign ev = (s2_q & ~s3_q) & {N{state_q == RUN}};
`endif
  assign send = v_i & ready_o;
  assign state_o = state_q;
  assign sdo_v_o = v_q;
  assign sdo_data_o = data_q;
  assign credit_err_o = err_q;
  always_comb begin
    state_d = state_q;
    if (!en_i) state_d = IDLE;
    else if (state_q == IDLE) state_d = CALIB;
    else if (state_q == CALIB && cnt_q == CNW'(calib_cycles_p-1)) state_d = RUN;
    cnt_d = (state_q == CALIB) ? cnt_q + 1'b1 : '0;
    ready_o = '0;
    sum = '0;
    cred_d = cred_q;
    err_d = err_q;
    data_d = data_q;
    if (reload) data_d = '1;
    else if (state_q == CALIB && state_d == CALIB) data_d = ~data_q;
    for (int c = 0; c < N; c++) begin
      ready_o[c] = run && (cred_q[c] != '0);
      sum[c] = (CW+1)'(cred_q[c]) - (CW+1)'(send[c]) + (ev[c] ? (CW+1)'(credit_decimation_p) : '0);
      if (reload) cred_d[c] = CW'(credits_p);
      else if (state_q == RUN) begin
        // Overflow saturates rather than wrapping; the sticky flag records it.
        cred_d[c] = (sum[c] > (CW+1)'(credits_p)) ? CW'(credits_p) : sum[c][CW-1:0];
        err_d[c] = err_q[c] | (sum[c] > (CW+1)'(credits_p));
      end
      if (send[c]) data_d[c*W +: W] = data_i[c*W +: W];
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      v_q     <= '0;
      err_q   <= '0;
      data_q  <= '0;
      cred_q  <= {N{CW'(credits_p)}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= sdo_token_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      v_q     <= send;
      err_q   <= err_d;
      data_q  <= data_d;
      cred_q  <= cred_d;
    end
  end
endmodule

// File: tb/tb_bsg_socket_sdo_tx.sv
// tb_bsg_socket_sdo_tx: directed self-checking bench for bsg_socket_sdo_tx with default parameters.
module tb_bsg_socket_sdo_tx;
  localparam int N = 4;
  localparam int W = 8;
`ifdef BSG_SOCKET_SDO_TX_TOKEN_DDR_EN
  localparam int TOK_PULSE = 8;
`else
  localparam int TOK_PULSE = 4;
`endif
  logic clk = 1'b0;
  logic reset_n, en;
  logic [N-1:0] v, ready, sdo_v, tok, err;
  logic [N*W-1:0] data, sdo_data;
  logic [1:0] state;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bsg_socket_sdo_tx dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .v_i(v), .data_i(data),
    .ready_o(ready), .sdo_v_o(sdo_v), .sdo_data_o(sdo_data), .sdo_token_i(tok),
    .state_o(state), .credit_err_o(err)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0;
    en = 1'b1;
    v = '0;
    data = '0;
    tok = '0;
    repeat (3) begin
      tick;
      check("rst_state", 32'(state), 32'd0);
    end
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_sdo_v", 32'(sdo_v), 32'd0);
    check("rst_data", sdo_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 32; i++) begin
      check("calib_state", 32'(state), 32'd1);
      check("calib_data", 32'(sdo_data[7:0]), (i % 2 == 0) ? 32'hFF : 32'h00);
      check("calib_v", 32'(sdo_v), 32'd0);
      tick;
    end
    check("run_state", 32'(state), 32'd2);
    for (int k = 0; k < 20; k++) begin
      v[0] = 1'b1;
      data[7:0] = 8'(8'h10 + k);
      check("burst_ready", 32'(ready[0]), 32'(k < 16));
      tick;
      check("burst_v", 32'(sdo_v[0]), 32'(k < 16));
      if (k < 16) check("burst_data", 32'(sdo_data[7:0]), 32'(8'h10 + k));
    end
    v = '0;
    tok[0] = 1'b1;
    tick;
    check("tok_lat1", 32'(ready[0]), 32'd0);
    tick;
    check("tok_lat2", 32'(ready[0]), 32'd0);
    tick;
    check("tok_lat3", 32'(ready[0]), 32'd1);
    tok[0] = 1'b0;
    repeat (4) tick;
    for (int k = 0; k < 12; k++) begin
      v[0] = 1'b1;
      check("tok_sends", 32'(ready[0]), 32'(k < TOK_PULSE));
      tick;
    end
    v = '0;
    tick;
    v[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data[23:16] = 8'(8'hA0 + k);
      tick;
      check("ch2_v", 32'(sdo_v[2]), 32'd1);
      check("ch2_data", 32'(sdo_data[23:16]), 32'(8'hA0 + k));
    end
    en = 1'b0;
    tick;
    check("drop_state", 32'(state), 32'd0);
    check("drop_v", 32'(sdo_v), 32'd0);
    check("drop_ready", 32'(ready), 32'd0);
    v = '0;
    tick;
    check("idle_state", 32'(state), 32'd0);
    en = 1'b1;
    tick;
    check("recal_data", sdo_data, 32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      check("recal_state", 32'(state), 32'd1);
      check("recal_v", 32'(sdo_v), 32'd0);
      tick;
    end
    check("rerun_state", 32'(state), 32'd2);
    for (int k = 0; k < 18; k++) begin
      v[2] = 1'b1;
      check("ch2_reload", 32'(ready[2]), 32'(k < 16));
      tick;
    end
    v = '0;
    for (int k = 0; k < 3; k++) begin
      v[0] = 1'b1;
      tick;
    end
    v = '0;
    tok[0] = 1'b1;
    tick;
    tick;
    v[0] = 1'b1;
    check("coin_ready", 32'(ready[0]), 32'd1);
    tick;
    v = '0;
    check("coin_v", 32'(sdo_v[0]), 32'd1);
    check("coin_err", 32'(err), 32'd0);
    tok[0] = 1'b0;
    repeat (4) tick;
    tok[0] = 1'b1;
    repeat (4) tick;
    check("ovf_err", 32'(err), 32'd1);
    tok[0] = 1'b0;
    repeat (4) tick;
    for (int k = 0; k < 18; k++) begin
      v[0] = 1'b1;
      check("sat_drain", 32'(ready[0]), 32'(k < 16));
      tick;
    end
    v = '0;
    check("err_sticky", 32'(err), 32'd1);
    v[1] = 1'b1;
    tick;
    tick;
    check("pre_rst_v", 32'(sdo_v[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_v", 32'(sdo_v), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_data", sdo_data, 32'd0);
    v = '0;
    tick;
    check("hold_rst_v", 32'(sdo_v), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
